// File: rtl/fp2_mul_arbiter.sv
// Round-robin arbiter sharing one Fp2 multiplier among N_REQ sequencing controllers.
// Optional watchdog in WAIT enabled by defining FP2_MUL_ARB_TIMEOUT_EN.
module fp2_mul_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned SEL_W          = $clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] req_done,
    output logic             mul_start,
    input  logic             mul_done,
    output logic [SEL_W-1:0] mul_sel,
    output logic             busy,
    output logic [15:0]      jobs_done,
    output logic             timeout_err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fp2_mul_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx, pick, sel_nx;
    logic [N_REQ-1:0] grant_nx, req_done_nx;
    logic             mul_start_nx, busy_nx;
    logic [15:0]      jobs_nx;
    int               idx;

`ifdef FP2_MUL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             to_set;
`endif

    // First requester at or after ptr+1 (mod N_REQ); lowest offset wins.
    always_comb begin
        pick = ptr;
        idx  = 0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            idx = (int'(ptr) + i) % int'(N_REQ);
            if (req[SEL_W'(idx)]) pick = SEL_W'(idx);
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        req_done_nx  = '0;
        mul_start_nx = 1'b0;
        sel_nx       = mul_sel;
        ptr_nx       = ptr;
        jobs_nx      = jobs_done;
`ifdef FP2_MUL_ARB_TIMEOUT_EN
        to_set       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                grant_nx = '0;
                if (|req) begin
                    state_nx     = S_START;
                    grant_nx     = N_REQ'(1) << pick;
                    sel_nx       = pick;
                    mul_start_nx = 1'b1;
                end
            end
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                // mul_done wins over a watchdog expiry in the same cycle
                if (mul_done) begin
                    state_nx    = S_DONE;
                    req_done_nx = grant;
                end
`ifdef FP2_MUL_ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx    = S_DONE;
                    req_done_nx = grant;
                    to_set      = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_nx = S_IDLE;
                grant_nx = '0;
                ptr_nx   = mul_sel;
                jobs_nx  = jobs_done + 16'd1;
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= SEL_W'(N_REQ - 1);
            grant     <= '0;
            req_done  <= '0;
            mul_start <= 1'b0;
            mul_sel   <= '0;
            busy      <= 1'b0;
            jobs_done <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            grant     <= grant_nx;
            req_done  <= req_done_nx;
            mul_start <= mul_start_nx;
            mul_sel   <= sel_nx;
            busy      <= busy_nx;
            jobs_done <= jobs_nx;
        end
    end

`ifdef FP2_MUL_ARB_TIMEOUT_EN
    // Watchdog: counts WAIT cycles; error flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_START) wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (to_set) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp2_mul_arbiter.sv
// Directed bench for fp2_mul_arbiter: grant scoreboard, latency, spurious done, reset, wrap, watchdog.
module tb_fp2_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, grant, req_done;
    logic        mul_start, mul_done, busy, timeout_err;
    logic [1:0]  mul_sel;
    logic [15:0] jobs_done;

    int tests = 0, fails = 0, now = 0;
    int lat = 1, cd = 0;
    bit auto_mul = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    fp2_mul_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .req_done(req_done),
        .mul_start(mul_start), .mul_done(mul_done), .mul_sel(mul_sel),
        .busy(busy), .jobs_done(jobs_done), .timeout_err(timeout_err)
    );

    // Multiplier model: mul_done pulses L cycles after the mul_start cycle
    always @(negedge clk) begin
        if (auto_mul) begin
            mul_done = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) mul_done = 1'b1;
            end
            if (mul_start === 1'b1) cd = lat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        now++;
    endtask

    task automatic expect_start(input string tag, output int t);
        int e;
        t = -1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (mul_start === 1'b1) begin
                t = now;
                break;
            end
        end
        chk({tag, "_start_seen"}, 32'(t >= 0), 1);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
        if (t >= 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sel"}, 32'(mul_sel), e);
            chk({tag, "_grant"}, 32'(grant), 32'(1) << e);
        end
    endtask

    task automatic wait_done(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (req_done !== 4'b0000) begin
                t = now;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(t >= 0), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_req_done"}, 32'(req_done), 0);
        chk({tag, "_mul_start"}, 32'(mul_start), 0);
        chk({tag, "_mul_sel"}, 32'(mul_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_jobs"}, 32'(jobs_done), 0);
        chk({tag, "_terr"}, 32'(timeout_err), 0);
    endtask

    initial begin
        int t0, t1, t2, first, prev;
        rst = 1'b1; req = 4'b0000; mul_done = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Round robin with all requests held, L=3
        lat = 3; auto_mul = 1'b1;
        req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        first = 0; prev = 0;
        for (int j = 0; j < 5; j++) begin
            expect_start("rr", t1);
            if (j == 0) first = t1;
            else chk("rr_period", t1 - prev, 6);
            prev = t1;
        end
        chk("rr_span", prev - first, 24);
        req = 4'b0000;
        wait_done("rr_last", t2);
        tick();
        chk("rr_busy_low", 32'(busy), 0);
        chk("rr_jobs", 32'(jobs_done), 5);

        // Single request on requester 2, L=5
        lat = 5;
        t0 = now;
        req = 4'b0100;
        exp_q.push_back(2);
        expect_start("single", t1);
        chk("single_start_cycle", t1 - t0, 1);
        chk("single_busy", 32'(busy), 1);
        wait_done("single", t2);
        chk("single_done_cycle", t2 - t0, 7);
        chk("single_req_done", 32'(req_done), 32'h4);
        req = 4'b0000;
        tick();
        chk("single_busy_low", 32'(busy), 0);
        chk("single_grant_clr", 32'(grant), 0);
        chk("single_jobs", 32'(jobs_done), 6);

        // Spurious mul_done in IDLE and in START
        auto_mul = 1'b0; mul_done = 1'b0;
        tick();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("spur_idle_busy", 32'(busy), 0);
        chk("spur_idle_jobs", 32'(jobs_done), 6);
        req = 4'b0001;
        exp_q.push_back(0);
        expect_start("spur", t1);
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("spur_start_busy", 32'(busy), 1);
        chk("spur_start_rd", 32'(req_done), 0);
        tick(); tick();
        chk("spur_wait_rd", 32'(req_done), 0);
        chk("spur_wait_grant", 32'(grant), 32'h1);
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("spur_real_done", 32'(req_done), 32'h1);
        req = 4'b0000;
        tick();
        chk("spur_busy_low", 32'(busy), 0);
        chk("spur_jobs", 32'(jobs_done), 7);

        // Asynchronous reset during WAIT
        req = 4'b0010;
        exp_q.push_back(1);
        expect_start("prerst", t1);
        tick();
        chk("prerst_wait_grant", 32'(grant), 32'h2);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        lat = 2; auto_mul = 1'b1;
        req = 4'b1010;
        exp_q.push_back(1);
        expect_start("postrst_a", t1);
        wait_done("postrst_a", t2);
        chk("postrst_a_rd", 32'(req_done), 32'h2);
        req = 4'b1000;
        exp_q.push_back(3);
        expect_start("postrst_b", t1);
        wait_done("postrst_b", t2);
        chk("postrst_b_rd", 32'(req_done), 32'h8);
        req = 4'b0000;
        tick();
        chk("postrst_jobs", 32'(jobs_done), 2);

        // Job counter wrap
        force dut.jobs_done = 16'hFFFF;
        tick();
        release dut.jobs_done;
        tick();
        req = 4'b0001;
        exp_q.push_back(0);
        expect_start("wrap", t1);
        wait_done("wrap", t2);
        req = 4'b0000;
        tick();
        chk("wrap_jobs", 32'(jobs_done), 0);

`ifdef FP2_MUL_ARB_TIMEOUT_EN
        // Watchdog: no mul_done at all
        auto_mul = 1'b0; mul_done = 1'b0;
        req = 4'b0100;
        exp_q.push_back(2);
        expect_start("to", t1);
        wait_done("to", t2);
        chk("to_latency", t2 - t1, 17);
        chk("to_req_done", 32'(req_done), 32'h4);
        chk("to_err", 32'(timeout_err), 1);
        req = 4'b0000;
        tick();
        chk("to_jobs", 32'(jobs_done), 1);
        lat = 2; auto_mul = 1'b1;
        req = 4'b0001;
        exp_q.push_back(0);
        expect_start("to_after", t1);
        wait_done("to_after", t2);
        req = 4'b0000;
        tick();
        chk("to_sticky", 32'(timeout_err), 1);
        chk("to_after_jobs", 32'(jobs_done), 2);
`else
        chk("terr_tied_low", 32'(timeout_err), 0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp2_mul_arbiter.md
# fp2_mul_arbiter

Round-robin arbiter that shares one Fp2 multiplier core among `N_REQ` sequencing controllers in the get_4_isog / isogeny datapath. Each requester holds `req` until the arbiter has started the multiplier on its behalf and the multiplier has reported completion. The arbiter drives `mul_start` and `mul_sel`; `mul_sel` steers the external operand/result memory muxes. It also keeps a wrapping completed-job counter for profiling.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `SEL_W`, `CLOG2(N_REQ)`: width of `mul_sel`.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in WAIT. Used only with `FP2_MUL_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  level request per requester; held until the matching `req_done` bit.
- `grant`  out  N_REQ  one-hot, registered; high from START through DONE for the served requester.
- `req_done`  out  N_REQ  one-cycle pulse to the served requester.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_done`  in  1  multiplier completion pulse.
- `mul_sel`  out  SEL_W  index of the served requester; stable while `grant` is nonzero.
- `busy`  out  1  high in every state except IDLE.
- `jobs_done`  out  16  completed-job count; wraps 0xFFFF→0x0000.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If any `req` is high, pick the first set bit scanning upward from `ptr+1` modulo `N_REQ`.
  - Register the pick into `grant` and `mul_sel`, then go to START.
  - If no `req` is high, stay in IDLE.
- START: `mul_start`=1 for exactly this cycle, then go to WAIT. `mul_done` is ignored in START.
- WAIT:
  - On `mul_done`=1, go to DONE.
  - `req` changes are ignored. Deasserting `req` does not abort a job.
- DONE:
  - `req_done[mul_sel]`=1.
  - `ptr`←`mul_sel`.
  - `jobs_done` increments.
  - Next state is IDLE, and `grant` clears on entry to IDLE.
- Requester contract: drop `req` on the clock edge that ends its `req_done` cycle. A `req` still high in the following IDLE cycle is a new request.
- Fairness: with all requests held continuously, grants rotate 0,1,2,…,N_REQ-1,0,…
- `mul_done` in IDLE or START is spurious. It is ignored and changes no state.
- Reset values, asserted asynchronously:
  - state=IDLE, `ptr`=N_REQ-1 (requester 0 wins first).
  - `grant`=0, `req_done`=0, `mul_start`=0, `mul_sel`=0, `busy`=0, `jobs_done`=0, `timeout_err`=0.
- Reset mid-job: the multiplier is not notified. The system controller resets it in the same reset domain.

## Timing
- Cycle 0: `req[i]` rises while in IDLE.
- Cycle 1: `grant[i]`, `mul_sel`=i, `mul_start` and `busy` all high.
- Cycle 1+L: `mul_done`, where L ≥ 1 is the multiplier latency.
- Cycle 2+L: `req_done[i]`=1; `jobs_done` shows the new value at cycle 3+L.
- Cycle 3+L: IDLE, `grant`=0, `busy`=0.
- Back-to-back jobs cost L+3 cycles each. The next grant appears at cycle 4+L.
- All outputs are registered; there are no combinational paths from `req` or `mul_done` to outputs.

## Configuration
- `FP2_MUL_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` with no `mul_done`, set `timeout_err` (sticky until `rst`), go to DONE, and pulse `req_done`.
  - `jobs_done` still increments on a timed-out job.
  - `mul_done` arriving in the same cycle as the limit is treated as normal completion; `timeout_err` is not set.
- `FP2_MUL_ARB_TIMEOUT_EN` undefined: no counter, WAIT waits indefinitely, `timeout_err` tied to 0.

## Test plan
- Single request, N_REQ=4: `req[2]` at cycle 0, multiplier L=5 → `mul_start` and `grant`=4'b0100 at cycle 1, `mul_sel`=2, `req_done`=4'b0100 at cycle 7, `busy` low at cycle 8, `jobs_done`=1.
- Round robin: `req`=4'b1111 held continuously, L=3 → grant order 0,1,2,3,0. The fifth `mul_start` comes 24 cycles after the first (6-cycle period).
- Spurious done: `mul_done` pulsed in IDLE and in the START cycle → no state change, `jobs_done` unchanged, job completes only on a later `mul_done`.
- Async reset: `rst` pulsed during WAIT with `grant`=4'b0010 → all outputs 0 immediately. After reset, with `req`=4'b1010, requester 1 is granted first.
- Counter wrap: preload via 65535 jobs, or force `jobs_done`=16'hFFFF, then run one job → `jobs_done`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): `mul_done` never asserted → `req_done` pulses 17 cycles after `mul_start` (16 WAIT cycles, then DONE) and `timeout_err`=1. It stays 1 through a later normal job.
